// File: rtl/dsi_pkg.sv
// rtl/dsi_pkg.sv - DSI data types, packet header struct, ECC helper and CRC polynomial
package dsi_pkg;

   localparam logic [5:0]  DT_GENERIC_LONG   = 6'h29;
   localparam logic [5:0]  DT_DCS_LONG_WRITE = 6'h39;
   localparam logic [5:0]  DT_RGB888_PACKED  = 6'h3E;
   // Bit-reversed form of x^16+x^12+x^5+1; DSI shifts each byte LSB first.
   localparam logic [15:0] CRC_POLY_REFL     = 16'h8408;
   localparam logic [15:0] CRC_SEED          = 16'hFFFF;

   typedef enum logic [1:0] {ST_IDLE, ST_PAY, ST_TAIL, ST_DRAIN} asm_state_t;

   typedef struct packed {
      logic [7:0]  ecc;
      logic [15:0] wc;
      logic [7:0]  di;
   } dsi_hdr_t;

   function automatic logic [7:0] dsi_ecc6(input logic [23:0] d);
      logic [7:0] e;
      e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      e[7:6] = 2'b00;
      return e;
   endfunction

endpackage

// File: rtl/dsi_crc64.sv
// rtl/dsi_crc64.sv - registered CRC-16 (DSI) advanced by one 64-bit beat per enable
module dsi_crc64
   import dsi_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        en,
   input  logic [63:0] data,
   output logic [15:0] crc
);

   // Byte 0 goes first and each byte is LSB first, so the serial order is simply data[0..63].
   function automatic logic [15:0] crc_step64(input logic [15:0] c_in, input logic [63:0] d);
      logic [15:0] c;
      c = c_in;
      for (int i = 0; i < 64; i++) begin
         if (c[0] ^ d[i])
            c = (c >> 1) ^ CRC_POLY_REFL;
         else
            c = c >> 1;
      end
      return c;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         crc <= CRC_SEED;
      else if (clr)
         crc <= CRC_SEED;
      else if (en)
         crc <= crc_step64(crc, data);
   end

endmodule

// File: rtl/dsi_long_pkt_asm.sv
// rtl/dsi_long_pkt_asm.sv - DSI long packet assembler, 8-byte beats; CRC engine enabled by DSI_PKT_CRC_EN
module dsi_long_pkt_asm
   import dsi_pkg::*;
#(
   parameter logic [15:0] MAX_WC   = 16'd4320,
   parameter logic [7:0]  PAD_BYTE = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_di,
   input  logic [15:0] cmd_wc,
   output logic        cmd_err,
   input  logic [63:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [63:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_first,
   output logic        out_last,
   output logic        busy
);

   asm_state_t  state, state_nxt;
   dsi_hdr_t    hdr;
   logic [12:0] beats, cnt;
   logic [31:0] hold;
   logic [15:0] crc;
   logic        out_free, out_fire, cmd_bad;
   logic        cmd_take, reject, load_beat, load_tail;

   assign out_free  = !out_valid || out_ready;
   assign out_fire  = out_valid && out_ready;
   assign cmd_bad   = (cmd_wc == 16'd0) || (cmd_wc[2:0] != 3'd0) || (cmd_wc > MAX_WC);
   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

`ifdef DSI_PKT_CRC_EN
   dsi_crc64 u_crc (
      .clk   (clk),
      .reset (reset),
      .clr   (cmd_take),
      .en    (load_beat),
      .data  (in_data),
      .crc   (crc)
   );
`else
   assign crc = 16'h0000;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      cmd_take  = 1'b0;
      reject    = 1'b0;
      load_beat = 1'b0;
      load_tail = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               if (cmd_bad) begin
                  reject = 1'b1;
               end else begin
                  cmd_take  = 1'b1;
                  state_nxt = ST_PAY;
               end
            end
         end
         ST_PAY: begin
            in_ready = out_free;
            if (in_valid && out_free) begin
               load_beat = 1'b1;
               if (cnt == beats - 13'd1)
                  state_nxt = ST_TAIL;
            end
         end
         ST_TAIL: begin
            if (out_free) begin
               load_tail = 1'b1;
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_fire)
               state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Each output beat pairs the low half of the new word with the upper half held from the previous one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hdr       <= '0;
         beats     <= '0;
         cnt       <= '0;
         hold      <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cmd_err <= reject;
         if (cmd_take) begin
            hdr.ecc <= dsi_ecc6({cmd_wc, cmd_di});
            hdr.wc  <= cmd_wc;
            hdr.di  <= cmd_di;
            beats   <= cmd_wc[15:3];
            cnt     <= '0;
         end
         if (load_beat) begin
            out_data  <= (cnt == 13'd0) ? {in_data[31:0], hdr} : {in_data[31:0], hold};
            out_first <= (cnt == 13'd0);
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            hold      <= in_data[63:32];
            cnt       <= cnt + 13'd1;
         end else if (load_tail) begin
            out_data  <= {PAD_BYTE, PAD_BYTE, crc[15:8], crc[7:0], hold};
            out_first <= 1'b0;
            out_last  <= 1'b1;
            out_valid <= 1'b1;
         end else if (out_fire) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dsi_long_pkt_asm.sv
// tb/tb_dsi_long_pkt_asm.sv - scoreboard bench with byte-stream reference model (honours DSI_PKT_CRC_EN)
module tb_dsi_long_pkt_asm;

   localparam logic [15:0] MAX_WC = 16'd4320;
   localparam logic [7:0]  PAD    = 8'h00;
   // Syndrome column of each header bit D0..D23 in the DSI Hamming code.
   localparam logic [5:0] ECC_COL [24] = '{
      6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
      6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
      6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
   localparam logic [7:0] T2_PAY [24] = '{
      8'hFF, 8'h00, 8'h00, 8'h00, 8'h1E, 8'hF0, 8'h1E, 8'hC7,
      8'h4F, 8'h82, 8'h78, 8'hC5, 8'h82, 8'hE0, 8'h8C, 8'h70,
      8'hD2, 8'h3C, 8'h78, 8'hE9, 8'hFF, 8'h00, 8'h00, 8'h01};
`ifdef DSI_PKT_CRC_EN
   localparam logic [15:0] T2_CRC = 16'hE569;
`else
   localparam logic [15:0] T2_CRC = 16'h0000;
`endif

   logic        clk = 1'b0, reset = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_err;
   logic [7:0]  cmd_di = '0;
   logic [15:0] cmd_wc = '0;
   logic [63:0] in_data = '0, out_data;
   logic        in_valid = 1'b0, in_ready;
   logic        out_valid, out_ready = 1'b1, out_first, out_last, busy;

   dsi_long_pkt_asm #(.MAX_WC(MAX_WC), .PAD_BYTE(PAD)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_di(cmd_di), .cmd_wc(cmd_wc), .cmd_err(cmd_err),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_first(out_first), .out_last(out_last), .busy(busy));

   always #5 clk = ~clk;

   typedef struct { logic [63:0] data; logic first; logic last; } beat_t;
   beat_t       exp_q[$];
   logic [7:0]  pay_q[$];
   int          checks = 0, errors = 0, err_pending = 0;
   bit          bp = 1'b0;
   logic [63:0] seen_first = '0, seen_last = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [7:0] ref_ecc(input logic [7:0] di, input logic [15:0] wc);
      logic [23:0] d;
      logic [5:0]  e;
      d = {wc, di};
      e = '0;
      for (int i = 0; i < 24; i++)
         if (d[i]) e ^= ECC_COL[i];
      return {2'b00, e};
   endfunction

   function automatic logic [15:0] ref_crc();
      logic [15:0] c;
      logic [7:0]  x;
      c = 16'hFFFF;
      foreach (pay_q[i]) begin
         x = pay_q[i] ^ c[7:0];
         x = x ^ (x << 4);
         c = {x, c[15:8]} ^ {12'h000, x[7:4]} ^ {5'b00000, x, 3'b000};
      end
`ifdef DSI_PKT_CRC_EN
      return c;
`else
      return 16'h0000;
`endif
   endfunction

   // Whole packet as a byte stream, then cut into 8-byte beats.
   task automatic expect_packet(input logic [7:0] di, input logic [15:0] wc);
      logic [7:0]  bytes[$];
      logic [15:0] c;
      beat_t       b;
      int          nb;
      bytes.push_back(di);
      bytes.push_back(wc[7:0]);
      bytes.push_back(wc[15:8]);
      bytes.push_back(ref_ecc(di, wc));
      foreach (pay_q[i]) bytes.push_back(pay_q[i]);
      c = ref_crc();
      bytes.push_back(c[7:0]);
      bytes.push_back(c[15:8]);
      bytes.push_back(PAD);
      bytes.push_back(PAD);
      nb = bytes.size() / 8;
      for (int n = 0; n < nb; n++) begin
         for (int k = 0; k < 8; k++) b.data[8*k +: 8] = bytes[8*n + k];
         b.first = (n == 0);
         b.last  = (n == nb - 1);
         exp_q.push_back(b);
      end
   endtask

   task automatic issue_cmd(input logic [7:0] di, input logic [15:0] wc, input bit good);
      int t = 0;
      while (!cmd_ready && t < 5000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("cmd_ready_wait", cmd_ready, 1'b1);
      if (good) expect_packet(di, wc);
      else err_pending++;
      cmd_valid = 1'b1;
      cmd_di    = di;
      cmd_wc    = wc;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (good) chk("cmd_ready_busy", cmd_ready, 1'b0);
   endtask

   task automatic send_payload(input int nwords, input int gap_pct);
      int t;
      for (int w = 0; w < nwords; w++) begin
         while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         for (int k = 0; k < 8; k++) in_data[8*k +: 8] = pay_q[8*w + k];
         t = 0;
         @(negedge clk);
         while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
         end
         if (!in_ready) chk("in_ready_timeout", in_ready, 1'b1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || busy) && t < 20000) begin
         @(negedge clk);
         t++;
      end
      chk(name, {exp_q.size() == 0, !busy}, 2'b11);
      @(posedge clk); #1;
   endtask

   task automatic run_packet(input logic [7:0] di, input logic [15:0] wc, input int gap, input bit rnd);
      if (rnd) begin
         pay_q.delete();
         for (int i = 0; i < wc; i++) pay_q.push_back(8'($urandom));
      end
      issue_cmd(di, wc, 1'b1);
      send_payload(wc / 8, gap);
   endtask

   task automatic load_t2();
      pay_q.delete();
      for (int i = 0; i < 24; i++) pay_q.push_back(T2_PAY[i]);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         out_ready = bp ? 1'($urandom_range(1)) : 1'b1;
      end
   end

   initial begin : monitor
      beat_t       b;
      bit          stall = 1'b0;
      logic [63:0] stall_data = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("stall_valid", out_valid, 1'b1);
               chk("stall_data", out_data, stall_data);
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_beat", out_valid, 1'b0);
               end else begin
                  b = exp_q.pop_front();
                  chk("beat_data", out_data, b.data);
                  chk("beat_first", out_first, b.first);
                  chk("beat_last", out_last, b.last);
                  if (b.first) seen_first = out_data;
                  if (b.last) seen_last = out_data;
               end
            end
            stall      = out_valid && !out_ready;
            stall_data = out_data;
            if (cmd_err && err_pending > 0) err_pending--;
            else if (err_pending == 0) chk("cmd_err_spurious", cmd_err, 1'b0);
            if (!busy) chk("in_ready_idle", in_ready, 1'b0);
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 64'h0);
      chk("rst_flags", {out_first, out_last, cmd_err, busy}, 4'b0000);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      run_packet(8'h37, 16'h01F0, 0, 1'b1);
      wait_drain("t1_drain");
      chk("t1_header", seen_first[31:0], 32'h3F01F037);

      load_t2();
      run_packet(8'h39, 16'd24, 0, 1'b0);
      wait_drain("t2_drain");
      chk("t2_tail_crc", seen_last[47:32], T2_CRC);
      chk("t2_tail_pad", seen_last[63:48], {PAD, PAD});

      foreach (T2_PAY[i]) begin
         if (i < 3) begin
            issue_cmd(8'h39, (i == 0) ? 16'd0 : (i == 1) ? 16'd12 : MAX_WC + 16'd8, 1'b0);
            repeat (2) @(negedge clk);
            chk("reject_idle", {busy, out_valid}, 2'b00);
         end
      end
      chk("reject_pulses", err_pending, 0);

      bp = 1'b1;
      load_t2();
      run_packet(8'h39, 16'd24, 0, 1'b0);
      wait_drain("t4_drain");
      chk("t4_tail_crc", seen_last[47:32], T2_CRC);

      run_packet(8'h29, 16'd8, 0, 1'b1);
      run_packet(8'h29, 16'd8, 0, 1'b1);
      wait_drain("t5_drain");

      bp = 1'b0;
      pay_q.delete();
      for (int i = 0; i < 32; i++) pay_q.push_back(8'($urandom));
      issue_cmd(8'h3E, 16'd32, 1'b1);
      send_payload(2, 0);
      reset = 1'b1;
      #1;
      chk("mid_rst_out", {out_valid, out_first, out_last, busy, in_ready}, 5'b00000);
      chk("mid_rst_data", out_data, 64'h0);
      chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      run_packet(8'h3E, 16'd16, 0, 1'b1);
      wait_drain("t6_after_reset");

      bp = 1'b1;
      run_packet(8'h29, MAX_WC, 20, 1'b1);
      for (int n = 0; n < 6; n++)
         run_packet(8'($urandom), 16'(8 * $urandom_range(1, 32)), 30, 1'b1);
      wait_drain("rand_drain");
      chk("final_err_pending", err_pending, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
